baser_257b_multilane_checker: RTL and testbench
===============================================

// Module: baser_257b_multilane_checker
// PURPOSE
//   N-lane successor of the single-channel 257b checker. Each lane takes pre-scrambler 256b/257b
//   transcoded blocks from the PCS generator (o_tx_coded_f0/f1 or more lanes) under a valid qualifier.
//   Per lane it classifies blocks, checks the data-character pattern and runs a block-lock state machine.
//   Saturating, software-clearable statistics are kept per lane. Verification-only block, not in the datapath.
// PARAMETERS
//   NUM_LANES          2      number of independent 257b lanes
//   TC_WIDTH           257    transcoded block width (1b header + 256b payload); fixed at 257
//   DATA_CHAR_PATTERN  8'hAA  expected value of every byte of an all-data block
//   CNT_WIDTH          32     width of each statistics counter
//   LOCK_GOOD          8      consecutive valid blocks needed to reach LOCKED (>=1)
//   LOCK_BAD           4      consecutive invalid blocks that drop LOCKED to HUNT (>=1)
// PORTS
//   clk                  in   1                     clock, all logic on rising edge
//   i_rst                in   1                     synchronous reset, active high
//   i_valid              in   NUM_LANES             lane k block present this cycle
//   i_rx_coded           in   NUM_LANES*TC_WIDTH    lane k block at [k*TC_WIDTH +: TC_WIDTH]
//   i_clear              in   1                     synchronous clear of all statistics counters
//   o_lock               out  NUM_LANES             lane k in LOCKED state
//   o_block_count        out  NUM_LANES*CNT_WIDTH   blocks received (valid cycles), lane k at [k*CNT_WIDTH +: CNT_WIDTH]
//   o_data_count         out  NUM_LANES*CNT_WIDTH   all-data blocks (header=1)
//   o_ctrl_count         out  NUM_LANES*CNT_WIDTH   well-formed blocks carrying >=1 control 64b block
//   o_inv_block_count    out  NUM_LANES*CNT_WIDTH   malformed blocks
//   o_pattern_err_count  out  NUM_LANES*CNT_WIDTH   all-data blocks with >=1 byte != DATA_CHAR_PATTERN
// BEHAVIOUR
//   Reset: synchronous, active high; clk and i_rst only. On i_rst all counters = 0, o_lock = 0,
//     every lane FSM = HUNT, good/bad run counters = 0. Reset mid-stream discards the block in flight.
//   Block format per lane (tc = lane slice):
//     - tc[0]=1: all-data; 64b block j = tc[64*j+1 +: 64], j=0..3.
//     - tc[0]=0: control block present; tc[4:1] = per-block flags (1 = data, 0 = control).
//   Classification of each valid block:
//     - tc[0]=0 and tc[4:1]=4'hF -> invalid.
//     - tc[0]=0 otherwise -> ctrl (valid).
//     - tc[0]=1 -> data (valid); any of its 32 bytes != DATA_CHAR_PATTERN -> pattern error.
//     - A pattern error does NOT make the block invalid.
//   Counters (each lane independent, evaluated only when i_valid[k]=1):
//     - block_count +1 every valid cycle.
//     - Exactly one of data/ctrl/inv +1 per block; pattern_err +1 when flagged.
//     - All counters saturate at 2^CNT_WIDTH-1; no wrap.
//   Latency: registered; a block sampled at edge n is reflected in counters and o_lock after edge n
//     (visible in cycle n+1). i_valid[k]=0 leaves all lane-k state unchanged.
//   i_clear: zeroes every counter of every lane at the next edge. Clear wins over a same-cycle
//     increment: that block is not counted. Lock FSMs are not affected by i_clear.
//   Lock FSM per lane (valid blocks only):
//     - HUNT: valid block -> good_run+1, else good_run=0.
//       Go LOCKED on the block that makes good_run==LOCK_GOOD; clear good_run and bad_run on entry.
//     - LOCKED: invalid block -> bad_run+1, valid block -> bad_run=0.
//       Go HUNT on the block that makes bad_run==LOCK_BAD; clear both runs on entry.
//     - Run counters sized $clog2(max(LOCK_GOOD,LOCK_BAD)+1); no overflow possible.
//     - o_lock[k] = (state==LOCKED), registered.
//   Lanes share nothing except clk, i_rst and i_clear.
// TESTING
//   1 Reset, then lane0 10 blocks {256{8'hAA} data, tc[0]=1} -> block=10, data=10, inv=0,
//     pattern_err=0; o_lock[0] rises the cycle after the 8th block; lane1 counters stay 0.
//   2 Lane1 tc[0]=0, tc[4:1]=4'b1110, 5 blocks -> ctrl=5, inv=0; then 3 blocks tc[4:1]=4'hF
//     -> inv=3, lock unchanged.
//   3 Lane0 locked, 4 consecutive invalid blocks -> o_lock[0]=0 after the 4th.
//     Same test with 3 invalid, 1 valid, 3 invalid -> stays locked.
//   4 Data block with byte 5 = 8'h55 -> pattern_err+1, data+1, inv+0, lock kept.
//   5 CNT_WIDTH=4, 20 data blocks -> block/data counts hold at 15.
//     i_clear with a coincident valid -> all counts 0 next cycle, o_lock unchanged.
//   6 i_rst asserted mid-stream on a locked lane -> all counts 0, o_lock=0 next cycle.
//     LOCK_GOOD fresh valid blocks are needed to relock.

Source files
------------

// File: rtl/baser_257b_multilane_checker.sv
// Per-lane 257b transcoded block checker: classification, data-pattern check,
// block-lock FSM and saturating, clearable statistics. Lanes are fully independent.
module baser_257b_multilane_checker #(
  parameter int unsigned NUM_LANES         = 2,
  parameter int unsigned TC_WIDTH          = 257,
  parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
  parameter int unsigned CNT_WIDTH         = 32,
  parameter int unsigned LOCK_GOOD         = 8,
  parameter int unsigned LOCK_BAD          = 4
) (
  input  logic                           clk,
  input  logic                           i_rst,
  input  logic [NUM_LANES-1:0]           i_valid,
  input  logic [NUM_LANES*TC_WIDTH-1:0]  i_rx_coded,
  input  logic                           i_clear,
  output logic [NUM_LANES-1:0]           o_lock,
  output logic [NUM_LANES*CNT_WIDTH-1:0] o_block_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0] o_data_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0] o_ctrl_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0] o_inv_block_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0] o_pattern_err_count
);

  localparam int unsigned RUN_MAX = (LOCK_GOOD > LOCK_BAD) ? LOCK_GOOD : LOCK_BAD;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] GOOD_LAST = RUN_W'(LOCK_GOOD - 1);
  localparam logic [RUN_W-1:0] BAD_LAST  = RUN_W'(LOCK_BAD - 1);

  typedef enum logic {HUNT, LOCKED} lock_state_t;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [TC_WIDTH-1:0]  tc;
    logic                 is_data, is_ctrl, is_inv, pat_err;
    logic [4:0]           inc;
    logic [CNT_WIDTH-1:0] cnt [5];
    lock_state_t          state, state_nxt;
    logic [RUN_W-1:0]     good_run, good_nxt, bad_run, bad_nxt;

    assign tc = i_rx_coded[k*TC_WIDTH +: TC_WIDTH];

    always_comb begin
      is_data = tc[0];
      is_inv  = !tc[0] && (tc[4:1] == 4'hF);
      is_ctrl = !tc[0] && !is_inv;
      pat_err = 1'b0;
      for (int unsigned b = 0; b < 32; b++) begin
        if (tc[8*b+1 +: 8] != DATA_CHAR_PATTERN) pat_err = 1'b1;
      end
      pat_err = pat_err && is_data;
    end

    // cnt[4]=block, [3]=data, [2]=ctrl, [1]=invalid, [0]=pattern error
    assign inc = {1'b1, is_data, is_ctrl, is_inv, pat_err};

    always_ff @(posedge clk) begin
      if (i_rst || i_clear) begin
        for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
      end else if (i_valid[k]) begin
        for (int unsigned i = 0; i < 5; i++) begin
          if (inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (i_rst) begin
        state    <= HUNT;
        good_run <= '0;
        bad_run  <= '0;
      end else begin
        state    <= state_nxt;
        good_run <= good_nxt;
        bad_run  <= bad_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      good_nxt  = good_run;
      bad_nxt   = bad_run;
      if (i_valid[k]) begin
        case (state)
          HUNT: begin
            if (is_inv) begin
              good_nxt = '0;
            end else if (good_run == GOOD_LAST) begin
              state_nxt = LOCKED;
              good_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              good_nxt = good_run + 1'b1;
            end
          end
          LOCKED: begin
            if (!is_inv) begin
              bad_nxt = '0;
            end else if (bad_run == BAD_LAST) begin
              state_nxt = HUNT;
              good_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_run + 1'b1;
            end
          end
          default: state_nxt = HUNT;
        endcase
      end
    end

    assign o_lock[k]                                   = (state == LOCKED);
    assign o_block_count[k*CNT_WIDTH +: CNT_WIDTH]       = cnt[4];
    assign o_data_count[k*CNT_WIDTH +: CNT_WIDTH]        = cnt[3];
    assign o_ctrl_count[k*CNT_WIDTH +: CNT_WIDTH]        = cnt[2];
    assign o_inv_block_count[k*CNT_WIDTH +: CNT_WIDTH]   = cnt[1];
    assign o_pattern_err_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt[0];
  end

endmodule

// File: tb/tb_baser_257b_multilane_checker.sv
// Table-driven bench for the multilane 257b checker, 4-bit counters so saturation is reachable.
module tb_baser_257b_multilane_checker;

  localparam int unsigned NL = 2;
  localparam int unsigned TW = 257;
  localparam int unsigned CW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NL-1:0]    valid = '0;
  logic [NL*TW-1:0] coded = '0;
  logic             clr = 1'b0;
  logic [NL-1:0]    lock;
  logic [NL*CW-1:0] blk_c, dat_c, ctl_c, inv_c, per_c;

  int checks = 0;
  int failures = 0;

  baser_257b_multilane_checker #(
    .NUM_LANES(NL), .TC_WIDTH(TW), .DATA_CHAR_PATTERN(8'hAA),
    .CNT_WIDTH(CW), .LOCK_GOOD(8), .LOCK_BAD(4)
  ) dut (
    .clk(clk), .i_rst(rst), .i_valid(valid), .i_rx_coded(coded), .i_clear(clr),
    .o_lock(lock), .o_block_count(blk_c), .o_data_count(dat_c), .o_ctrl_count(ctl_c),
    .o_inv_block_count(inv_c), .o_pattern_err_count(per_c)
  );

  always #5 clk = ~clk;

  // kind: 0 good data, 1 ctrl (flags 1110), 2 invalid (flags F), 3 data with byte 5 = 55
  function automatic logic [TW-1:0] mk(input logic [1:0] kind);
    logic [TW-1:0] t;
    t = '0;
    case (kind)
      2'd0: t = {{32{8'hAA}}, 1'b1};
      2'd1: t[4:1] = 4'b1110;
      2'd2: t[4:1] = 4'hF;
      default: begin
        t = {{32{8'hAA}}, 1'b1};
        t[48:41] = 8'h55;
      end
    endcase
    return t;
  endfunction

  // packed as one hex digit per counter: {block, data, ctrl, inv, pattern_err}
  function automatic logic [19:0] lane_cnt(input int unsigned k);
    return {blk_c[k*CW +: CW], dat_c[k*CW +: CW], ctl_c[k*CW +: CW],
            inv_c[k*CW +: CW], per_c[k*CW +: CW]};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] k0, input logic [1:0] k1,
                       input logic c, input logic r);
    valid = v;
    coded = {mk(k1), mk(k0)};
    clr   = c;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned rep;
    logic [1:0]  v;
    logic [1:0]  k0;
    logic [1:0]  k1;
    logic        c;
    logic        r;
    logic [1:0]  lk;
    logic [19:0] e0;
    logic [19:0] e1;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{2,  2'b00, 0, 0, 0, 1, 2'b00, 20'h00000, 20'h00000}); // reset state
    tbl.push_back('{7,  2'b01, 0, 0, 0, 0, 2'b00, 20'h77000, 20'h00000}); // 7 data, no lock
    tbl.push_back('{1,  2'b01, 0, 0, 0, 0, 2'b01, 20'h88000, 20'h00000}); // 8th -> lock
    tbl.push_back('{2,  2'b01, 0, 0, 0, 0, 2'b01, 20'hAA000, 20'h00000}); // 10 data
    tbl.push_back('{5,  2'b10, 0, 1, 0, 0, 2'b01, 20'hAA000, 20'h50500}); // lane1 ctrl
    tbl.push_back('{3,  2'b10, 0, 2, 0, 0, 2'b01, 20'hAA000, 20'h80530}); // lane1 invalid
    tbl.push_back('{1,  2'b00, 0, 0, 1, 0, 2'b01, 20'h00000, 20'h00000}); // clear
    tbl.push_back('{3,  2'b01, 2, 0, 0, 0, 2'b01, 20'h30030, 20'h00000}); // 3 invalid
    tbl.push_back('{1,  2'b01, 0, 0, 0, 0, 2'b01, 20'h41030, 20'h00000}); // 1 valid
    tbl.push_back('{3,  2'b01, 2, 0, 0, 0, 2'b01, 20'h71060, 20'h00000}); // 3 invalid, locked
    tbl.push_back('{1,  2'b01, 2, 0, 0, 0, 2'b00, 20'h81070, 20'h00000}); // 4th -> unlock
    tbl.push_back('{1,  2'b00, 0, 0, 1, 0, 2'b00, 20'h00000, 20'h00000}); // clear
    tbl.push_back('{7,  2'b01, 0, 0, 0, 0, 2'b00, 20'h77000, 20'h00000});
    tbl.push_back('{1,  2'b01, 0, 0, 0, 0, 2'b01, 20'h88000, 20'h00000}); // relock
    tbl.push_back('{1,  2'b01, 3, 0, 0, 0, 2'b01, 20'h99001, 20'h00000}); // pattern error
    tbl.push_back('{11, 2'b01, 0, 0, 0, 0, 2'b01, 20'hFF001, 20'h00000}); // saturate at 15
    tbl.push_back('{1,  2'b11, 0, 2, 1, 0, 2'b01, 20'h00000, 20'h00000}); // clear beats inc
    tbl.push_back('{3,  2'b00, 2, 2, 0, 0, 2'b01, 20'h00000, 20'h00000}); // idle ignored
    tbl.push_back('{2,  2'b01, 0, 0, 0, 0, 2'b01, 20'h22000, 20'h00000});
    tbl.push_back('{1,  2'b01, 0, 0, 0, 1, 2'b00, 20'h00000, 20'h00000}); // mid-stream reset
    tbl.push_back('{7,  2'b01, 0, 0, 0, 0, 2'b00, 20'h77000, 20'h00000});
    tbl.push_back('{1,  2'b01, 0, 0, 0, 0, 2'b01, 20'h88000, 20'h00000}); // relock after reset
    tbl.push_back('{8,  2'b10, 0, 1, 0, 0, 2'b11, 20'h88000, 20'h80800}); // lane1 locks on ctrl

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int unsigned n = 0; n < tbl[i].rep; n++)
        drive(tbl[i].v, tbl[i].k0, tbl[i].k1, tbl[i].c, tbl[i].r);
      check($sformatf("row%0d_lock", i), {18'd0, lock}, {18'd0, tbl[i].lk});
      check($sformatf("row%0d_lane0", i), lane_cnt(0), tbl[i].e0);
      check($sformatf("row%0d_lane1", i), lane_cnt(1), tbl[i].e1);
    end

    // lane1 drops lock exactly on the 4th consecutive invalid block
    for (int n = 1; n <= 4; n++) begin
      drive(2'b10, 0, 2, 0, 0);
      check($sformatf("drop_inv%0d", n), {18'd0, lock}, {18'd0, (n < 4) ? 2'b11 : 2'b01});
    end

    // idle cycles between valid blocks do not break the good run
    for (int n = 1; n <= 8; n++) begin
      drive(2'b10, 0, 1, 0, 0);
      drive(2'b00, 0, 2, 0, 0);
      check($sformatf("gap_relock%0d", n), {19'd0, lock[1]}, {19'd0, n == 8});
    end
    check("gap_lane1_cnt", lane_cnt(1), 20'hF0F40);

    valid = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
